jellyvl_etherneco_synctimer_scheduler: RTL

JELLYVL_ETHERNECO_SYNCTIMER_SCHEDULER -- requirements
Module: jellyvl_etherneco_synctimer_scheduler

---
 rtl/jellyvl_etherneco_synctimer_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/jellyvl_etherneco_synctimer_scheduler.sv
// rtl/jellyvl_etherneco_synctimer_scheduler.sv - periodic sync-timer frame scheduler
//
// Purpose : every param_period cycles emits an 11-byte sync frame
//           (command, 64-bit local time LE, 16-bit offset LE). It then waits for
//           the response, extracts the node-0 round trip time and reports
//           timeouts and period overruns.
// Option  : JELLYVL_SYNCTIMER_SCHED_AUTO_OFFSET_EN - when defined, the transmitted
//           offset is half the latest valid round_trip, saturated to 16 bits.
//           When undefined, param_offset is sampled at frame start.
// Ports   : clk, reset_n (async, active low)
//           enable, param_period, param_timeout, param_offset  - configuration
//           current_time                                       - local master time
//           m_cmd_*                                            - command byte stream
//           res_rx_start/end/error, s_res_*                    - response stream
//           busy, round_trip, round_trip_valid,
//           timeout_error, overrun                             - status
module jellyvl_etherneco_synctimer_scheduler #(
  parameter int TIMER_WIDTH  = 64,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] param_period,
  input  logic [PERIOD_WIDTH-1:0] param_timeout,
  input  logic [15:0]             param_offset,
  input  logic [TIMER_WIDTH-1:0]  current_time,
  output logic                    m_cmd_first,
  output logic                    m_cmd_last,
  output logic [15:0]             m_cmd_pos,
  output logic [7:0]              m_cmd_data,
  output logic                    m_cmd_valid,
  input  logic                    m_cmd_ready,
  input  logic                    res_rx_start,
  input  logic                    res_rx_end,
  input  logic                    res_rx_error,
  input  logic [15:0]             s_res_pos,
  input  logic [7:0]              s_res_data,
  input  logic                    s_res_valid,
  output logic                    busy,
  output logic [31:0]             round_trip,
  output logic                    round_trip_valid,
  output logic                    timeout_error,
  output logic                    overrun
);

  typedef enum logic [2:0] {IDLE, WAIT_PERIOD, SEND, WAIT_RES, UPDATE} state_t;

  state_t                  state, next_state;
  logic [PERIOD_WIDTH-1:0] period_cnt, period_limit, wait_cnt;
  logic                    period_hit, overrun_pend, sync_lost;
  logic [3:0]              pos;
  logic [7:0]              cmd_byte;
  logic [63:0]             time_lat;
  logic [15:0]             off_lat, offset_src;
  logic [31:0]             rt_shadow;
  logic [127:0]            frame;
  logic                    xfer, rx_ok, tmo, send_start;

  // period of 0 behaves like 1
  assign period_limit = (param_period == '0) ? '0 : param_period - PERIOD_WIDTH'(1);
  assign period_hit   = (period_cnt == period_limit);
  assign xfer         = (state == SEND) && m_cmd_ready;
  assign rx_ok        = res_rx_end && !res_rx_error;
  assign tmo          = ((wait_cnt + PERIOD_WIDTH'(1)) == param_timeout);
  assign send_start   = (state == WAIT_PERIOD) && (next_state == SEND);

`ifdef JELLYVL_SYNCTIMER_SCHED_AUTO_OFFSET_EN
  // round_trip is 0 until the first measurement, giving offset 0
  assign offset_src = (|round_trip[31:17]) ? 16'hFFFF : round_trip[16:1];
`else
  assign offset_src = param_offset;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (enable) next_state = WAIT_PERIOD;
      WAIT_PERIOD: begin
        if (!enable)                         next_state = IDLE;
        else if (period_hit || overrun_pend) next_state = SEND;
      end
      SEND:        if (xfer && pos == 4'd10) next_state = WAIT_RES;
      WAIT_RES: begin
        // error wins over a coincident end; any response event wins over timeout
        if (res_rx_error) next_state = WAIT_PERIOD;
        else if (rx_ok)   next_state = UPDATE;
        else if (tmo)     next_state = WAIT_PERIOD;
      end
      UPDATE:      next_state = WAIT_PERIOD;
      default:     next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt    <= '0;
      wait_cnt      <= '0;
      overrun_pend  <= 1'b0;
      overrun       <= 1'b0;
      timeout_error <= 1'b0;
      sync_lost     <= 1'b1;
      pos           <= 4'd0;
    end else begin
      overrun       <= 1'b0;
      timeout_error <= 1'b0;

      if (state == IDLE || send_start) period_cnt <= '0;
      else                             period_cnt <= period_cnt + PERIOD_WIDTH'(1);

      if (state == WAIT_RES) wait_cnt <= wait_cnt + PERIOD_WIDTH'(1);
      else                   wait_cnt <= '0;

      // the pending flag makes the pulse one-shot and forces an immediate
      // frame start at the next WAIT_PERIOD
      if (state == IDLE || send_start) begin
        overrun_pend <= 1'b0;
      end else if (state != WAIT_PERIOD && period_hit && !overrun_pend) begin
        overrun_pend <= 1'b1;
        overrun      <= 1'b1;
      end

      if (state == WAIT_RES && !res_rx_error && !rx_ok && tmo) timeout_error <= 1'b1;

      if (state == IDLE)                                           sync_lost <= 1'b1;
      else if (state == UPDATE)                                    sync_lost <= 1'b0;
      else if (state == WAIT_RES && next_state == WAIT_PERIOD)     sync_lost <= 1'b1;

      if (state != SEND) pos <= 4'd0;
      else if (xfer)     pos <= pos + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_byte   <= 8'h00;
      time_lat   <= 64'd0;
      off_lat    <= 16'd0;
      rt_shadow  <= 32'd0;
      round_trip <= 32'd0;
    end else begin
      if (send_start) begin
        cmd_byte <= sync_lost ? 8'h03 : 8'h01;
        time_lat <= 64'(current_time);
        off_lat  <= offset_src;
      end
      if (state == WAIT_RES) begin
        if (res_rx_start) rt_shadow <= 32'd0;
        if (s_res_valid) begin
          case (s_res_pos)
            16'd9:   rt_shadow[7:0]   <= s_res_data;
            16'd10:  rt_shadow[15:8]  <= s_res_data;
            16'd11:  rt_shadow[23:16] <= s_res_data;
            16'd12:  rt_shadow[31:24] <= s_res_data;
            default: ;
          endcase
        end
      end
      // only a clean response publishes the measurement
      if (state == UPDATE) round_trip <= rt_shadow;
    end
  end

  assign frame            = {40'd0, off_lat, time_lat, cmd_byte};
  assign m_cmd_valid      = (state == SEND);
  assign m_cmd_first      = m_cmd_valid && (pos == 4'd0);
  assign m_cmd_last       = m_cmd_valid && (pos == 4'd10);
  assign m_cmd_pos        = {12'd0, pos};
  assign m_cmd_data       = frame[{pos, 3'b000} +: 8];
  assign busy             = (state == SEND) || (state == WAIT_RES) || (state == UPDATE);
  assign round_trip_valid = (state == UPDATE);

endmodule
